// File: rtl/uart_pkg.sv
// Shared UART definitions used by the load/store decode and the transmit path.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_tx_state_t;

    // Address bits [31:12] value that selects the UART page
    localparam logic [19:0] UART_PAGE      = 20'd1;
    localparam int          UART_DATA_BITS = 8;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO; a push while full is accepted only when a pop frees a slot in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_full;
    logic             r_empty;

    logic             w_pop_ok;
    logic             w_push_ok;
    logic [CNT_W-1:0] w_count_next;

    assign w_pop_ok  = i_pop & ~r_empty;
    assign w_push_ok = i_push & (~r_full | w_pop_ok);

    always_comb begin
        w_count_next = r_count;
        case ({w_push_ok, w_pop_ok})
            2'b10:   w_count_next = r_count + CNT_W'(1);
            2'b01:   w_count_next = r_count - CNT_W'(1);
            default: w_count_next = r_count;
        endcase
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= w_count_next;
            r_full  <= (w_count_next == CNT_W'(DEPTH));
            r_empty <= (w_count_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_full  = r_full;
    assign o_empty = r_empty;
    assign o_count = r_count;

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: store strobes are queued in a FIFO and
// serialised LSB first, with back-to-back frames when the queue is not empty.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       byte_ready_i,
    input  logic [7:0] data_in,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       fifo_full,
    output logic       fifo_empty,
    output logic       overflow
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        BIT_LAST  = 3'(UART_DATA_BITS - 1);

    uart_tx_state_t r_state;
    uart_tx_state_t w_state_next;
    logic [BAUD_W-1:0] r_baud;
    logic [BAUD_W-1:0] w_baud_next;
    logic [2:0]        r_bit_idx;
    logic [2:0]        w_bit_idx_next;
    logic [7:0]        r_shift;
    logic [7:0]        w_shift_next;
    logic              r_tx;
    logic              r_busy;
    logic              r_done;
    logic              r_overflow;
    logic              w_tx_next;
    logic              w_baud_last;
    logic              w_pop;
    logic [7:0]        w_fifo_rdata;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [CNT_W-1:0]  w_fifo_count;
    logic              w_fifo_at_cap;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (byte_ready_i),
        .i_pop   (w_pop),
        .i_wdata (data_in),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    assign w_baud_last   = (r_baud == BAUD_LAST);
    assign w_fifo_at_cap = (w_fifo_count == CNT_W'(FIFO_DEPTH));
    // A pop on the last STOP cycle chains the next frame with no idle gap
    assign w_pop = ~w_fifo_empty &
                   ((r_state == IDLE) | ((r_state == STOP) & w_baud_last));

    always_comb begin
        w_state_next   = r_state;
        w_shift_next   = r_shift;
        w_bit_idx_next = r_bit_idx;
        case (r_state)
            IDLE: begin
                if (w_pop) begin
                    w_state_next = START;
                    w_shift_next = w_fifo_rdata;
                end
            end
            START: begin
                if (w_baud_last) begin
                    w_state_next   = DATA;
                    w_bit_idx_next = '0;
                end
            end
            DATA: begin
                if (w_baud_last) begin
                    w_shift_next = r_shift >> 1;
                    if (r_bit_idx == BIT_LAST) w_state_next   = STOP;
                    else                       w_bit_idx_next = r_bit_idx + 3'd1;
                end
            end
            STOP: begin
                if (w_baud_last) begin
                    if (w_pop) begin
                        w_state_next = START;
                        w_shift_next = w_fifo_rdata;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase

        if ((w_state_next != r_state) || (r_state == IDLE) || w_baud_last)
            w_baud_next = '0;
        else
            w_baud_next = r_baud + BAUD_W'(1);

        case (w_state_next)
            START:   w_tx_next = 1'b0;
            DATA:    w_tx_next = w_shift_next[0];
            default: w_tx_next = 1'b1;
        endcase
    end

    // Outputs are registered from next-state values so they align with the state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_baud     <= '0;
            r_bit_idx  <= '0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_baud     <= w_baud_next;
            r_bit_idx  <= w_bit_idx_next;
            r_tx       <= w_tx_next;
            r_busy     <= (w_state_next != IDLE);
            r_done     <= (w_state_next == STOP) && (w_baud_next == BAUD_LAST);
            r_overflow <= r_overflow | (byte_ready_i & w_fifo_at_cap & ~w_pop);
        end
    end

    always_ff @(posedge clk) begin
        r_shift <= w_shift_next;
    end

    assign tx         = r_tx;
    assign tx_busy    = r_busy;
    assign tx_done    = r_done;
    assign fifo_full  = w_fifo_full;
    assign fifo_empty = w_fifo_empty;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered: a line monitor decodes frames, a scoreboard holds the bytes expected on tx.
module tb_uart_tx_buffered;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       byte_ready_i;
    logic [7:0] data_in;
    logic       tx;
    logic       tx_busy;
    logic       tx_done;
    logic       fifo_full;
    logic       fifo_empty;
    logic       overflow;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] sb[$];

    logic [7:0] rx_byte  [64];
    logic       rx_start [64];
    logic       rx_stop  [64];
    logic       rx_done  [64];
    int         rx_cnt    = 0;
    int         rd_idx    = 0;
    int         abort_cnt = 0;

    int busy_run = 0;
    int last_run = 0;
    int n_done   = 0;

    uart_tx_buffered #(
        .CLKS_PER_BIT (4),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .byte_ready_i (byte_ready_i),
        .data_in      (data_in),
        .tx           (tx),
        .tx_busy      (tx_busy),
        .tx_done      (tx_done),
        .fifo_full    (fifo_full),
        .fifo_empty   (fifo_empty),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tx_done === 1'b1) n_done <= n_done + 1;
        if (tx_busy === 1'b1) begin
            busy_run <= busy_run + 1;
        end else begin
            if (busy_run != 0) last_run <= busy_run;
            busy_run <= 0;
        end
    end

    // Frame decoder: start edge seen on negedge = frame cycle 1; sample mid-bit.
    initial begin
        logic       prev;
        logic [7:0] b;
        logic       s0;
        logic       s1;
        logic       dn;
        int         ab;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && prev === 1'b1 && tx === 1'b0) begin
                ab = abort_cnt;
                @(negedge clk);
                s0 = tx;
                for (int i = 0; i < 8; i++) begin
                    repeat (4) @(negedge clk);
                    b[i] = tx;
                end
                repeat (4) @(negedge clk);
                s1 = tx;
                repeat (2) @(negedge clk);
                dn = tx_done;
                if (ab == abort_cnt && rx_cnt < 64) begin
                    rx_byte[rx_cnt]  = b;
                    rx_start[rx_cnt] = s0;
                    rx_stop[rx_cnt]  = s1;
                    rx_done[rx_cnt]  = dn;
                    rx_cnt++;
                end
            end
            prev = tx;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic strobe(input logic [7:0] b, input bit accept);
        byte_ready_i = 1'b1;
        data_in      = b;
        if (accept) sb.push_back(b);
        @(negedge clk);
        byte_ready_i = 1'b0;
        data_in      = 8'h00;
    endtask

    task automatic drain(input int n);
        int         cyc;
        logic [7:0] e;
        cyc = 0;
        while ((rx_cnt < rd_idx + n || tx_busy) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        check("drain_timeout", 32'(cyc >= 3000), 32'd0);
        repeat (2) @(negedge clk);
        for (int k = 0; k < n; k++) begin
            if (rd_idx < rx_cnt) begin
                check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("rx_byte", 32'(rx_byte[rd_idx]), 32'(e));
                end
                check("start_bit", 32'(rx_start[rd_idx]), 32'd0);
                check("stop_bit", 32'(rx_stop[rd_idx]), 32'd1);
                check("done_on_last_stop", 32'(rx_done[rd_idx]), 32'd1);
                rd_idx++;
            end
        end
        check("sb_drained", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int d0;
        int saved;
        bit seen;
        byte_ready_i = 1'b0;
        data_in      = 8'h00;
        rst_n        = 1'b1;
        #1 rst_n     = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(tx_busy), 32'd0);
        check("rst_done", 32'(tx_done), 32'd0);
        check("rst_full", 32'(fifo_full), 32'd0);
        check("rst_empty", 32'(fifo_empty), 32'd1);
        check("rst_overflow", 32'(overflow), 32'd0);
        rst_n = 1'b1;

        // Idle line for 50 cycles
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            check("idle_line", {28'd0, tx, fifo_empty, tx_busy, overflow}, 32'b1100);
        end

        // Single byte 0xA5
        d0 = n_done;
        strobe(8'hA5, 1'b1);
        check("empty_falls", 32'(fifo_empty), 32'd0);
        @(negedge clk);
        check("tx_low_after_pop", 32'(tx), 32'd0);
        drain(1);
        check("a5_done_pulses", 32'(n_done - d0), 32'd1);
        check("a5_busy_len", 32'(last_run), 32'd40);

        // Three back-to-back bytes
        d0 = n_done;
        strobe(8'h01, 1'b1);
        strobe(8'h02, 1'b1);
        strobe(8'h03, 1'b1);
        drain(3);
        check("b2b_done_pulses", 32'(n_done - d0), 32'd3);
        check("b2b_busy_len", 32'(last_run), 32'd120);

        // Six strobes: fill the FIFO, last one overflows
        d0 = n_done;
        for (int k = 0; k < 5; k++) strobe(8'h10 + 8'(k), 1'b1);
        check("fill_full", 32'(fifo_full), 32'd1);
        check("fill_no_ovf", 32'(overflow), 32'd0);
        strobe(8'h15, 1'b0);
        check("ovf_set", 32'(overflow), 32'd1);
        drain(5);
        check("ovf_sticky", 32'(overflow), 32'd1);
        check("ovf_done_pulses", 32'(n_done - d0), 32'd5);
        check("ovf_busy_len", 32'(last_run), 32'd200);

        // Reset during DATA bit 3 of 0x3C with two bytes queued
        strobe(8'h3C, 1'b0);
        strobe(8'h3D, 1'b0);
        strobe(8'h3E, 1'b0);
        repeat (16) @(negedge clk);
        check("pre_rst_busy", 32'(tx_busy), 32'd1);
        saved = rx_cnt;
        #2 rst_n = 1'b0;
        abort_cnt++;
        #1;
        check("async_rst_tx", 32'(tx), 32'd1);
        check("async_rst_busy", 32'(tx_busy), 32'd0);
        check("async_rst_empty", 32'(fifo_empty), 32'd1);
        check("async_rst_ovf", 32'(overflow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            check("post_rst_idle", {30'd0, tx, fifo_empty}, 32'b11);
        end
        check("no_frame_after_rst", 32'(rx_cnt), 32'(saved));

        // Full FIFO, strobe on the STOP-final pop cycle
        d0 = n_done;
        for (int k = 0; k < 5; k++) strobe(8'h20 + 8'(k), 1'b1);
        check("full_again", 32'(fifo_full), 32'd1);
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            if (tx_done === 1'b1) seen = 1'b1;
            else @(negedge clk);
        end
        check("stop_final_seen", 32'(seen), 32'd1);
        strobe(8'h25, 1'b1);
        check("pop_push_full", 32'(fifo_full), 32'd1);
        check("pop_push_no_ovf", 32'(overflow), 32'd0);
        drain(6);
        check("final_no_ovf", 32'(overflow), 32'd0);
        check("final_done_pulses", 32'(n_done - d0), 32'd6);
        check("final_busy_len", 32'(last_run), 32'd240);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
